// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported word memory.
// One transaction in flight at a time. Sub-word stores use read-modify-write.
// Misaligned data accesses are answered with an error and never reach memory.
module mem_port_arbiter #(
    parameter int unsigned RR_ENABLE = 1
) (
    input  logic        clock,
    input  logic        reset,

    // Fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    // Data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_err,
    output logic [31:0] d_rdata,

    // Main memory
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_read_write
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRead     = 3'd1,
        StWrite    = 3'd2,
        StRmwWrite = 3'd3,
        StResp     = 3'd4
    } state_e;

    state_e      state_q;
    logic        last_i_q;    // 1 when the most recent grant went to the fetch port
    logic        owner_d_q;   // 1 when the data port owns the current transaction
    logic        we_q;
    logic        half_q;      // sub-word store size: 1 = half, 0 = byte
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;     // only the low half is needed for sub-word merges

    logic        i_rvalid_q;
    logic [31:0] i_rdata_q;
    logic        d_rvalid_q;
    logic        d_err_q;
    logic [31:0] d_rdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_rw_q;

    logic        in_idle;
    logic        pick_d;
    logic        d_word;
    logic        d_misaligned;
    logic [31:0] rmw_data_d;

    // Fetch addresses are word-aligned by dropping the low bits.
    logic        unused_i_addr_lsb;
    assign unused_i_addr_lsb = ^i_addr[1:0];

    // Arbitration: data wins unless round-robin says fetch is due.
    always_comb begin
        in_idle      = (state_q == StIdle);
        pick_d       = d_req && (!i_req || (RR_ENABLE == 0) || last_i_q);
        i_gnt        = in_idle && i_req && !pick_d;
        d_gnt        = in_idle && pick_d;
        d_word       = d_size[1];
        d_misaligned = d_word ? (d_addr[1:0] != 2'b00) : (d_size[0] && d_addr[0]);
    end

    // Merge the store lanes into the word read back from memory.
    always_comb begin
        rmw_data_d = mem_data_out;
        if (half_q) begin
            if (lane_q[1]) begin
                rmw_data_d[31:16] = wdata_q;
            end else begin
                rmw_data_d[15:0] = wdata_q;
            end
        end else begin
            rmw_data_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Transaction FSM with registered memory and response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            last_i_q    <= 1'b1;
            owner_d_q   <= 1'b0;
            we_q        <= 1'b0;
            half_q      <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= 16'h0;
            i_rvalid_q  <= 1'b0;
            i_rdata_q   <= 32'h0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= 32'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_rw_q    <= 1'b0;
        end else begin
            // Responses and write strobes are single-cycle unless re-armed below.
            i_rvalid_q  <= 1'b0;
            i_rdata_q   <= 32'h0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_rw_q    <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (d_gnt) begin
                        last_i_q  <= 1'b0;
                        owner_d_q <= 1'b1;
                        we_q      <= d_we;
                        half_q    <= d_size[0];
                        lane_q    <= d_addr[1:0];
                        wdata_q   <= d_wdata[15:0];
                        if (d_misaligned) begin
                            state_q    <= StResp;
                            d_rvalid_q <= 1'b1;
                            d_err_q    <= 1'b1;
                        end else if (d_we && d_word) begin
                            state_q     <= StWrite;
                            mem_addr_q  <= {d_addr[31:2], 2'b00};
                            mem_wdata_q <= d_wdata;
                            mem_rw_q    <= 1'b1;
                        end else begin
                            state_q    <= StRead;
                            mem_addr_q <= {d_addr[31:2], 2'b00};
                        end
                    end else if (i_gnt) begin
                        last_i_q   <= 1'b1;
                        owner_d_q  <= 1'b0;
                        we_q       <= 1'b0;
                        state_q    <= StRead;
                        mem_addr_q <= {i_addr[31:2], 2'b00};
                    end
                end

                StRead: begin
                    if (owner_d_q && we_q) begin
                        state_q     <= StRmwWrite;
                        mem_wdata_q <= rmw_data_d;
                        mem_rw_q    <= 1'b1;
                    end else begin
                        state_q <= StResp;
                        if (owner_d_q) begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= mem_data_out;
                        end else begin
                            i_rvalid_q <= 1'b1;
                            i_rdata_q  <= mem_data_out;
                        end
                    end
                end

                StWrite, StRmwWrite: begin
                    state_q    <= StResp;
                    d_rvalid_q <= 1'b1;
                end

                StResp: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign i_rvalid       = i_rvalid_q;
    assign i_rdata        = i_rdata_q;
    assign d_rvalid       = d_rvalid_q;
    assign d_err          = d_err_q;
    assign d_rdata        = d_rdata_q;
    assign mem_address    = mem_addr_q;
    assign mem_data_in    = mem_wdata_q;
    assign mem_read_write = mem_rw_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance with a word
// memory model, plus a fixed-priority instance driven by the same requests.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, mem_read_write;
    logic [31:0] i_rdata, d_rdata, mem_address, mem_data_in, mem_data_out;

    logic        fp_i_gnt, fp_i_rvalid, fp_d_gnt, fp_d_rvalid, fp_d_err, fp_mem_rw;
    logic [31:0] fp_i_rdata, fp_d_rdata, fp_mem_address, fp_mem_data_in, fp_mem_data_out;

    logic [31:0] mem [0:255];
    int          n_writes;
    int          n_total;
    int          n_bad;

    mem_port_arbiter #(.RR_ENABLE(1)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_gnt          (i_gnt),
        .i_rvalid       (i_rvalid),
        .i_rdata        (i_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_size         (d_size),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .d_err          (d_err),
        .d_rdata        (d_rdata),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_read_write (mem_read_write)
    );

    mem_port_arbiter #(.RR_ENABLE(0)) u_fp (
        .clock          (clock),
        .reset          (reset),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_gnt          (fp_i_gnt),
        .i_rvalid       (fp_i_rvalid),
        .i_rdata        (fp_i_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_size         (d_size),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_gnt          (fp_d_gnt),
        .d_rvalid       (fp_d_rvalid),
        .d_err          (fp_d_err),
        .d_rdata        (fp_d_rdata),
        .mem_address    (fp_mem_address),
        .mem_data_in    (fp_mem_data_in),
        .mem_data_out   (fp_mem_data_out),
        .mem_read_write (fp_mem_rw)
    );

    assign fp_mem_data_out = 32'h0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory: combinational read, write committed on the rising edge.
    assign mem_data_out = mem[mem_address[9:2]];
    always @(posedge clock) begin
        if (mem_read_write) begin
            mem[mem_address[9:2]] <= mem_data_in;
            n_writes <= n_writes + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic start_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        start_cycle();
        reset = 1'b1;
        start_cycle();
        reset = 1'b0;
    endtask

    task automatic drive_d(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
        d_req   = 1'b1;
        d_we    = we;
        d_size  = size;
        d_addr  = addr;
        d_wdata = wdata;
    endtask

    int          w0;
    int          ng;
    int          fp_d_cnt;
    int          fp_i_cnt;
    int          both_cnt;
    logic [3:0]  order;
    logic        saw_rw;
    logic        saw_rvalid;

    initial begin
        n_total  = 0;
        n_bad    = 0;
        n_writes = 0;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        mem[1]    = 32'h00F0F093;
        mem[8'h40] = 32'h11223344;

        reset = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_addr = 32'h0; d_wdata = 32'h0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst_rw", {31'h0, mem_read_write}, 32'h0);
        check("rst_addr", mem_address, 32'h0);
        check("rst_wdata", mem_data_in, 32'h0);
        check("rst_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
        start_cycle();
        reset = 1'b0;

        // Fetch: gnt in cycle 0, rvalid in cycle 2
        start_cycle();
        i_req = 1'b1; i_addr = 32'h01000004;
        @(negedge clock);
        check("fetch_gnt", {30'h0, i_gnt, d_gnt}, 32'h2);
        start_cycle();
        i_req = 1'b0;
        @(negedge clock);
        check("fetch_rd_addr", mem_address, 32'h01000004);
        check("fetch_rd_rw", {31'h0, mem_read_write}, 32'h0);
        check("fetch_early_rvalid", {31'h0, i_rvalid}, 32'h0);
        start_cycle();
        @(negedge clock);
        check("fetch_rvalid", {31'h0, i_rvalid}, 32'h1);
        check("fetch_rdata", i_rdata, 32'h00F0F093);

        // Fetch with unaligned low bits: address aligned, no error
        start_cycle();
        i_req = 1'b1; i_addr = 32'h01000007;
        @(negedge clock);
        check("fetch2_gnt", {31'h0, i_gnt}, 32'h1);
        start_cycle();
        i_req = 1'b0;
        @(negedge clock);
        check("fetch2_addr", mem_address, 32'h01000004);
        start_cycle();
        @(negedge clock);
        check("fetch2_resp", {29'h0, i_rvalid, d_rvalid, d_err}, 32'h4);

        // Byte store: READ, RMW write of merged word, rvalid at gnt+3
        w0 = n_writes;
        start_cycle();
        drive_d(1'b1, 2'd0, 32'h01000102, 32'h000000AB);
        @(negedge clock);
        check("bst_gnt", {31'h0, d_gnt}, 32'h1);
        start_cycle();
        d_req = 1'b0;
        @(negedge clock);
        check("bst_read", {mem_address[31:1], mem_read_write}, {31'h00800080, 1'b0});
        start_cycle();
        @(negedge clock);
        check("bst_rmw_rw", {31'h0, mem_read_write}, 32'h1);
        check("bst_rmw_data", mem_data_in, 32'h11AB3344);
        check("bst_early_rvalid", {31'h0, d_rvalid}, 32'h0);
        start_cycle();
        @(negedge clock);
        check("bst_resp", {30'h0, d_rvalid, d_err}, 32'h2);
        check("bst_rdata", d_rdata, 32'h0);
        check("bst_resp_rw", {31'h0, mem_read_write}, 32'h0);
        check("bst_writes", n_writes - w0, 32'h1);
        check("bst_mem", mem[8'h40], 32'h11AB3344);

        // Half store into the low half of the same word
        start_cycle();
        drive_d(1'b1, 2'd1, 32'h01000100, 32'h0000CAFE);
        @(negedge clock);
        start_cycle();
        d_req = 1'b0;
        start_cycle();
        @(negedge clock);
        check("hst_rmw_data", mem_data_in, 32'h11ABCAFE);
        start_cycle();
        @(negedge clock);
        check("hst_resp", {30'h0, d_rvalid, d_err}, 32'h2);

        // Word load returns the merged word
        start_cycle();
        drive_d(1'b0, 2'd2, 32'h01000100, 32'h0);
        @(negedge clock);
        start_cycle();
        d_req = 1'b0;
        start_cycle();
        @(negedge clock);
        check("ld_resp", {30'h0, d_rvalid, d_err}, 32'h2);
        check("ld_rdata", d_rdata, 32'h11ABCAFE);

        // Size 3 word store: 2-cycle latency, direct write
        w0 = n_writes;
        start_cycle();
        drive_d(1'b1, 2'd3, 32'h01000008, 32'h12345678);
        @(negedge clock);
        start_cycle();
        d_req = 1'b0;
        @(negedge clock);
        check("wst_rw", {31'h0, mem_read_write}, 32'h1);
        check("wst_data", mem_data_in, 32'h12345678);
        start_cycle();
        @(negedge clock);
        check("wst_resp", {30'h0, d_rvalid, d_err}, 32'h2);
        check("wst_mem", mem[2], 32'h12345678);
        check("wst_writes", n_writes - w0, 32'h1);

        // Misaligned word store: error one cycle after gnt, no memory write
        w0 = n_writes;
        saw_rw = 1'b0;
        start_cycle();
        drive_d(1'b1, 2'd2, 32'h01000006, 32'hFFFFFFFF);
        @(negedge clock);
        check("mis_gnt", {31'h0, d_gnt}, 32'h1);
        saw_rw = saw_rw | mem_read_write;
        start_cycle();
        d_req = 1'b0;
        @(negedge clock);
        saw_rw = saw_rw | mem_read_write;
        check("mis_resp", {30'h0, d_rvalid, d_err}, 32'h3);
        start_cycle();
        @(negedge clock);
        saw_rw = saw_rw | mem_read_write;
        check("mis_no_rw", {31'h0, saw_rw}, 32'h0);
        check("mis_writes", n_writes - w0, 32'h0);
        check("mis_mem", mem[1], 32'h00F0F093);

        // Misaligned half load flags an error too
        start_cycle();
        drive_d(1'b0, 2'd1, 32'h01000101, 32'h0);
        @(negedge clock);
        start_cycle();
        d_req = 1'b0;
        @(negedge clock);
        check("mis_half", {30'h0, d_rvalid, d_err}, 32'h3);

        // Reset during WRITE: strobe drops asynchronously, no rvalid
        w0 = n_writes;
        saw_rvalid = 1'b0;
        start_cycle();
        drive_d(1'b1, 2'd2, 32'h0100000C, 32'hDEADBEEF);
        @(negedge clock);
        start_cycle();
        d_req = 1'b0;
        @(negedge clock);
        check("rw_in_write", {31'h0, mem_read_write}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("async_rw_drop", {31'h0, mem_read_write}, 32'h0);
        check("async_wdata_drop", mem_data_in, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            saw_rvalid = saw_rvalid | d_rvalid | i_rvalid;
        end
        start_cycle();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            saw_rvalid = saw_rvalid | d_rvalid | i_rvalid;
            start_cycle();
        end
        check("rst_no_rvalid", {31'h0, saw_rvalid}, 32'h0);
        check("rst_no_write", n_writes - w0, 32'h0);
        check("rst_mem", mem[3], 32'h0);
        i_req = 1'b1; i_addr = 32'h01000004;
        @(negedge clock);
        check("rst_idle_gnt", {31'h0, i_gnt}, 32'h1);
        start_cycle();
        i_req = 1'b0;
        start_cycle();
        @(negedge clock);
        check("rst_fetch_rdata", i_rdata, 32'h00F0F093);

        // Both ports held: RR gives D,I,D,I; fixed priority gives only D
        do_reset();
        ng = 0; fp_d_cnt = 0; fp_i_cnt = 0; both_cnt = 0; order = 4'h0;
        i_req = 1'b1; i_addr = 32'h01000004;
        drive_d(1'b0, 2'd2, 32'h01000100, 32'h0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (d_gnt && i_gnt) both_cnt++;
            if (d_gnt && ng < 4) begin order[ng] = 1'b1; ng++; end
            else if (i_gnt && ng < 4) begin order[ng] = 1'b0; ng++; end
            if (fp_d_gnt) fp_d_cnt++;
            if (fp_i_gnt) fp_i_cnt++;
            start_cycle();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check("rr_count", ng, 32'd4);
        check("rr_order", {28'h0, order}, 32'h5);
        check("rr_one_gnt", both_cnt, 32'd0);
        check("fp_d_count", fp_d_cnt, 32'd4);
        check("fp_i_starved", fp_i_cnt, 32'd0);

        repeat (4) start_cycle();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
